// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising serial PRBS checker with lock detect,
// windowed sync-loss detection and saturating error/bit counters
module prbs_checker #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter int unsigned      LOCK_GOOD  = 32,
  parameter int unsigned      WIN        = 256,
  parameter int unsigned      ERR_THRESH = 8,
  parameter int unsigned      CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned WCNT_W = $clog2(WIN + 1);
  localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
  localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WIN - 1);
  localparam logic [WERR_W-1:0] THRESH    = WERR_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [WCNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d, win_err_inc;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  logic               locked_q, locked_d, err_pulse_q, err_pulse_d;
  logic               sync_loss_q, sync_loss_d;
  logic               pred;

  assign pred = ^(hist_q & TAPS);

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    good_d      = good_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    win_err_inc = win_err_q + 1'b1;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    if (din_valid) begin
      case (state_q)
        SEED: begin
          hist_d = {hist_q[WIDTH-2:0], din};
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            state_d = VERIFY;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        VERIFY: begin
          hist_d = {hist_q[WIDTH-2:0], din};
          if (din == pred) begin
            if (good_q == GOOD_LAST) begin
              good_d  = '0;
              state_d = LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d  = '0;
            fill_d  = '0;
            state_d = SEED;
          end
        end
        LOCKED: begin
          // Free-running feedback keeps a single flipped bit from echoing through the taps.
          hist_d = {hist_q[WIDTH-2:0], pred};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
          if (din != pred) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (win_err_inc == THRESH) begin
              sync_loss_d = 1'b1;
              state_d     = SEED;
              fill_d      = '0;
              good_d      = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else if (win_cnt_q != WIN_LAST) begin
              win_err_d = win_err_inc;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEED;
      hist_q      <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - randomized bench for prbs_checker against a rule-level model
// (default instance plus a CNT_W=4 / ERR_THRESH=256 instance on the same stream)
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, din_valid, din, clear;
  logic        locked, err_pulse, sync_loss;
  logic [31:0] err_cnt, bit_cnt;
  logic        locked_s, err_pulse_s, sync_loss_s;
  logic [3:0]  err_cnt_s, bit_cnt_s;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs_checker #(.CNT_W(4), .ERR_THRESH(256)) dut_s (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked_s), .err_pulse(err_pulse_s), .sync_loss(sync_loss_s),
    .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: instance 0 = defaults, instance 1 = CNT_W 4 / ERR_THRESH 256
  logic [15:0] tp = 16'hB400;
  int     m_ph[2], m_fill[2], m_good[2], m_wc[2], m_we[2];
  longint m_ec[2], m_bc[2];
  bit     m_lk[2], m_ep[2], m_sl[2];
  bit     m_h[2][16];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ph[m] = 0; m_fill[m] = 0; m_good[m] = 0; m_wc[m] = 0; m_we[m] = 0;
      m_ec[m] = 0; m_bc[m] = 0; m_lk[m] = 0; m_ep[m] = 0; m_sl[m] = 0;
      for (int k = 0; k < 16; k++) m_h[m][k] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit v, input bit d, input bit clr);
    int     et;
    longint mx;
    bit     p, fb;
    et = (m == 0) ? 8 : 256;
    mx = (m == 0) ? 64'd4294967295 : 64'd15;
    m_ep[m] = 1'b0;
    m_sl[m] = 1'b0;
    if (v) begin
      p = 1'b0;
      for (int k = 1; k <= 16; k++) if (tp[k-1]) p ^= m_h[m][k-1];
      fb = (m_ph[m] == 2) ? p : d;
      for (int k = 15; k > 0; k--) m_h[m][k] = m_h[m][k-1];
      m_h[m][0] = fb;
      if (m_ph[m] == 0) begin
        m_fill[m]++;
        if (m_fill[m] == 16) begin m_fill[m] = 0; m_ph[m] = 1; end
      end else if (m_ph[m] == 1) begin
        if (d == p) begin
          m_good[m]++;
          if (m_good[m] == 32) begin m_good[m] = 0; m_ph[m] = 2; m_lk[m] = 1'b1; end
        end else begin
          m_good[m] = 0; m_fill[m] = 0; m_ph[m] = 0;
        end
      end else begin
        if (m_bc[m] < mx) m_bc[m]++;
        if (d != p) begin
          if (m_ec[m] < mx) m_ec[m]++;
          m_ep[m] = 1'b1;
          m_we[m]++;
          if (m_we[m] == et) begin
            m_sl[m] = 1'b1; m_ph[m] = 0; m_lk[m] = 1'b0;
            m_fill[m] = 0; m_good[m] = 0; m_wc[m] = 0; m_we[m] = 0;
          end
        end
        if (!m_sl[m]) begin
          if (m_wc[m] == 255) begin m_wc[m] = 0; m_we[m] = 0; end
          else m_wc[m]++;
        end
      end
    end
    if (clr) begin m_ec[m] = 0; m_bc[m] = 0; end
  endtask

  logic [15:0] gh;
  int nbits, lock_idx, sl_idx, sl_cnt, ep_cnt, base;
  bit prev_lk;

  task automatic tick(input bit v, input bit d, input bit clr);
    din_valid = v; din = d; clear = clr;
    for (int m = 0; m < 2; m++) begin
      if (rst) model_reset();
      else model_step(m, v, d, clr);
    end
    @(posedge clk); #1;
    check("locked",      locked,      m_lk[0]);
    check("err_pulse",   err_pulse,   m_ep[0]);
    check("sync_loss",   sync_loss,   m_sl[0]);
    check("err_cnt",     err_cnt,     m_ec[0]);
    check("bit_cnt",     bit_cnt,     m_bc[0]);
    check("locked_s",    locked_s,    m_lk[1]);
    check("err_pulse_s", err_pulse_s, m_ep[1]);
    check("sync_loss_s", sync_loss_s, m_sl[1]);
    check("err_cnt_s",   err_cnt_s,   m_ec[1]);
    check("bit_cnt_s",   bit_cnt_s,   m_bc[1]);
    if (sync_loss) begin sl_cnt++; sl_idx = nbits; end
    if (err_pulse) ep_cnt++;
    if (locked && !prev_lk) lock_idx = nbits;
    prev_lk = locked;
  endtask

  task automatic send(input bit flip, input bit clr);
    bit g;
    if ($urandom_range(0, 7) == 0) tick(1'b0, 1'($urandom), 1'b0);
    g  = ^(gh & tp);
    gh = {gh[14:0], g};
    nbits++;
    tick(1'b1, g ^ flip, clr);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; clear = 1'b0;
    gh = 16'($urandom) | 16'h0001;
    nbits = 0; lock_idx = -1; sl_idx = -1; sl_cnt = 0; ep_cnt = 0; prev_lk = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
    check("clean_lock_at", lock_idx, 48);
    check("clean_bit_cnt", bit_cnt, 952);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_pulses", ep_cnt, 0);

    ep_cnt = 0; sl_cnt = 0;
    for (int i = 0; i < 150; i++) send(i == 25 || i == 75 || i == 125, 1'b0);
    check("single_pulses", ep_cnt, 3);
    check("single_err_cnt", err_cnt, 3);
    check("single_locked", locked, 1);
    check("single_sync_loss", sl_cnt, 0);

    send(1'b0, 1'b1);
    check("clear_err_cnt", err_cnt, 0);
    check("clear_bit_cnt", bit_cnt, 0);
    check("clear_bit_cnt_s", bit_cnt_s, 0);

    while (((nbits - 48) % 256) != 0) send(1'b0, 1'b0);
    ep_cnt = 0; sl_cnt = 0;
    for (int i = 0; i < 512; i++)
      send((i >= 200 && i <= 248 && (i - 200) % 8 == 0) ||
           (i >= 258 && i <= 306 && (i - 258) % 8 == 0), 1'b0);
    check("window_err_cnt", err_cnt, 14);
    check("window_sync_loss", sl_cnt, 0);
    check("window_locked", locked, 1);

    while (((nbits - 48) % 256) != 0) send(1'b0, 1'b0);
    sl_cnt = 0; base = nbits;
    for (int i = 0; i < 200; i++) send(i < 80 && (i % 10) == 5, 1'b0);
    check("burst_sync_loss_cnt", sl_cnt, 1);
    check("burst_sync_loss_at", sl_idx, base + 76);
    check("burst_relock_at", lock_idx, base + 124);
    check("burst_err_cnt", err_cnt, 22);
    check("burst_locked_s", locked_s, 1);

    #3 rst = 1'b1;
    #1;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_sync_loss", sync_loss, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err_cnt_s", err_cnt_s, 0);
    check("rst_locked_s", locked_s, 0);
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    nbits = 0; lock_idx = -1; prev_lk = 1'b0;

    for (int i = 0; i < 100; i++) send(i == 29, 1'b0);
    check("verify_fail_lock_at", lock_idx, 78);

    sl_cnt = 0; base = nbits;
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
    check("sat_sync_loss_at", sl_idx, base + 8);
    check("sat_err_cnt", err_cnt, 8);
    check("sat_err_cnt_s", err_cnt_s, 15);
    check("sat_bit_cnt_s", bit_cnt_s, 15);
    check("sat_locked_s", locked_s, 1);
    tick(1'b0, 1'b0, 1'b1);
    check("sat_clear_err_s", err_cnt_s, 0);
    check("sat_clear_bit_s", bit_cnt_s, 0);

    for (int i = 0; i < 1500; i++)
      send($urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
